// File: rtl/button_event_if.sv
// button_event_if: groups the debounced button level and the event outputs
// of one button_event instance.
//
// Signals:
//   btn           debounced, synchronised button level (active high)
//   press         one-cycle pulse when the button goes down
//   release_pulse one-cycle pulse when the button comes up
//                 (the plain name "release" is a reserved word)
//   long_press    one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse  one-cycle pulse every REPEAT_CYCLES while held
//                 (the plain name "repeat" is a reserved word)
//   held          level, high while the button is in the long-held state
//   dbg_state     current state of the event FSM, for observation only
//
// Modports:
//   master  upstream side: drives btn, receives the events
//   slave   the button_event block itself
//
// Handshake: there is no valid/ready pair. btn is a level sampled on every
// rising clock edge; every event output is a registered one-cycle pulse that
// the consumer must sample in the cycle it is high.
interface button_event_if;
    logic       btn;
    logic       press;
    logic       release_pulse;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [1:0] dbg_state;

    modport master (
        output btn,
        input  press, release_pulse, long_press, repeat_pulse, held, dbg_state
    );

    modport slave (
        input  btn,
        output press, release_pulse, long_press, repeat_pulse, held, dbg_state
    );
endinterface

// File: rtl/button_event.sv
// button_event: turns a clean button level into single-cycle event pulses
// (press, release, long-press, auto-repeat) plus a "held" level.
//
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous, active-high reset; returns to IDLE silently (no
//        release pulse even if the button was down)
//   bus  button_event_if.slave: btn in; press, release_pulse, long_press,
//        repeat_pulse, held, dbg_state out (all registered)
//
// Parameters:
//   LONG_CYCLES    cycles high after the press edge before long_press (>= 2)
//   REPEAT_CYCLES  cycles between repeat pulses once long-held (>= 1)
//   REPEAT_EN      1 = issue repeat pulses while held, 0 = suppress them
module button_event #(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    button_event_if.slave        bus
);

    // Smallest width able to hold the value max_val.
    function automatic int cnt_width(input longint max_val);
        int w;
        w = 0;
        while ((64'sd1 <<< w) <= max_val) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    localparam int MAX_CYC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = cnt_width(longint'(MAX_CYC));

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             press_r;
    logic             release_r;
    logic             long_r;
    logic             repeat_r;
    logic             held_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            // Pulses default low so each one lasts exactly one cycle.
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.btn) begin
                        state   <= PRESSED;
                        press_r <= 1'b1;
                    end
                end

                PRESSED: begin
                    // btn low is tested first so a release on the terminal
                    // count wins over long_press.
                    if (!bus.btn) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        release_r <= 1'b1;
                    end else if (cnt == LONG_LAST) begin
                        state  <= HELD;
                        cnt    <= '0;
                        long_r <= 1'b1;
                        held_r <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                HELD: begin
                    if (!bus.btn) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        release_r <= 1'b1;
                        held_r    <= 1'b0;
                    end else if (!REPEAT_EN) begin
                        cnt <= '0;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt      <= '0;
                        repeat_r <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    held_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.press         = press_r;
    assign bus.release_pulse = release_r;
    assign bus.long_press    = long_r;
    assign bus.repeat_pulse  = repeat_r;
    assign bus.held          = held_r;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: two button_event instances (repeat enabled / disabled)
// share clk, rst and the button level. A reference model based on the count
// of consecutive high samples predicts each cycle's output vector; the
// driver pushes predictions, a monitor on the falling edge pops and compares.
module tb_button_event;

    localparam int L = 8;
    localparam int R = 4;

    logic clk;
    logic rst;

    button_event_if if_a ();
    button_event_if if_b ();

    button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    // Vector layout: {press, release, long_press, repeat, held}
    logic [4:0] exp_a_q[$];
    logic [4:0] exp_b_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int run    = 0;  // consecutive edges with btn high since IDLE
    int n_long = 0;
    int n_rep  = 0;

    // ---------------- driver tasks ----------------
    task automatic step(input logic b, input logic r);
        logic p, rl, lp, rp, h;
        if_a.btn = b;
        if_b.btn = b;
        rst      = r;
        @(posedge clk);
        #1;
        cyc++;
        p = 1'b0; rl = 1'b0; lp = 1'b0; rp = 1'b0; h = 1'b0;
        if (r) begin
            run = 0;
        end else if (b) begin
            run = run + 1;
            p  = (run == 1);
            lp = (run == L + 1);
            h  = (run >= L + 1);
            rp = (run > L + 1) && (((run - (L + 1)) % R) == 0);
        end else begin
            rl  = (run > 0);
            run = 0;
        end
        if (lp) n_long++;
        if (rp) n_rep++;
        exp_a_q.push_back({p, rl, lp, rp, h});
        exp_b_q.push_back({p, rl, lp, 1'b0, h});
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [4:0] e;
        logic [4:0] g;
        if (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            g = {if_a.press, if_a.release_pulse, if_a.long_press, if_a.repeat_pulse, if_a.held};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rep_en1 cycle %0d: got {p,r,lp,rp,h}=%b expected %b", cyc, g, e);
            end
        end
        if (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            g = {if_b.press, if_b.release_pulse, if_b.long_press, if_b.repeat_pulse, if_b.held};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rep_en0 cycle %0d: got {p,r,lp,rp,h}=%b expected %b", cyc, g, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        if_a.btn = 1'b0;
        if_b.btn = 1'b0;
        rst      = 1'b1;

        // Reset held with btn high, then released with btn high: press follows.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        hold(3);            // short tap
        gap(2);
        hold(21);           // long hold: long_press, three repeats
        gap(2);
        hold(8);            // tie at the long_press edge
        gap(2);
        hold(12);           // tie at the first repeat edge
        gap(2);
        hold(31);           // long hold; repeat-disabled instance sees none
        gap(2);
        hold(10);           // reset while held
        step(1'b1, 1'b1);
        hold(3);
        gap(2);
        hold(1);            // back-to-back single-cycle taps
        gap(1);
        hold(1);
        gap(1);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) step(1'($urandom_range(0, 1)), 1'b1);
            hold($urandom_range(1, 26));
            gap($urandom_range(1, 3));
        end

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expectations, required 0/0",
                     exp_a_q.size(), exp_b_q.size());
        end
        $display("stimulus: %0d cycles, %0d long_press and %0d repeat expected; final state a=%0d b=%0d",
                 cyc, n_long, n_rep, if_a.dbg_state, if_b.dbg_state);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the input debouncer; consumes its clean, active-high button level.
- Converts that level into single-cycle event pulses for the control FSM: press, release, long-press and auto-repeat.
- Lets menu/selection logic step a value once per press, or continuously while the button is held.
- One instance per debounced button.

Parameters:
- LONG_CYCLES, 50000000, cycles the button must stay high after press before long_press fires; legal range >= 2.
- REPEAT_CYCLES, 10000000, cycles between successive repeat pulses once long-held; legal range >= 1.
- REPEAT_EN, 1, 1 enables repeat pulses in HELD; 0 suppresses them.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn  input  1  debounced, already-synchronised button level, active high.
- press  output  1  one-cycle pulse on press.
- release  output  1  one-cycle pulse on release.
- long_press  output  1  one-cycle pulse when hold reaches LONG_CYCLES.
- repeat  output  1  one-cycle pulse every REPEAT_CYCLES while in HELD.
- held  output  1  level; high while in HELD state.

Behaviour:
- Reset: one clock; reset is synchronous and active-high, on clk/rst as named above. When rst is sampled high: state=IDLE, counter=0, all outputs 0. rst overrides every other event, including mid-hold; no release pulse is generated by reset.
- All outputs are registered. Pulses are exactly one cycle wide.
- Counter: one counter, width = ceil(log2(max(LONG_CYCLES, REPEAT_CYCLES)+1)) computed by a constant function. Never wraps: cleared on every state transition and on each repeat.
- State machine (states IDLE, PRESSED, HELD); sampling at each rising edge:
- IDLE, btn=1: go to PRESSED, counter<=0, press<=1.
- IDLE, btn=0: stay in IDLE.
- PRESSED, btn=0: go to IDLE, release<=1.
- PRESSED, btn=1, counter==LONG_CYCLES-1: go to HELD, counter<=0, long_press<=1, held<=1.
- PRESSED, btn=1, otherwise: counter++.
- HELD, btn=0: go to IDLE, release<=1, held<=0.
- HELD, btn=1, REPEAT_EN=1, counter==REPEAT_CYCLES-1: repeat<=1, counter<=0.
- HELD, btn=1, REPEAT_EN=1, otherwise: counter++.
- HELD, btn=1, REPEAT_EN=0: counter stays 0; no repeat pulses.
- Latency: btn first sampled high at edge E0 -> press high during cycle E0..E1. long_press high during the cycle after edge E0+LONG_CYCLES. First repeat after edge E0+LONG_CYCLES+REPEAT_CYCLES, then every REPEAT_CYCLES.
- Release: btn first sampled low at edge Er -> release high during cycle Er..Er+1. In HELD, held drops at the same edge.
- Simultaneous events: btn low at the edge where the counter hits its terminal value -> release wins; no long_press or repeat is issued.
- Pulse exclusivity: press and release are never high in the same cycle. A one-cycle btn high gives press, then release on the next cycle.
- Back-to-back: release followed by btn high at the next edge -> fresh press from IDLE; one cycle gap minimum.

Test Plan:
- Bench parameters: LONG_CYCLES=8, REPEAT_CYCLES=4, REPEAT_EN=1 unless noted.
- Reset: hold rst 3 cycles with btn=1 -> all outputs 0 throughout. Release rst with btn=1 -> press 1 cycle after the first non-reset edge.
- Short tap: btn high 3 cycles -> press pulse at cycle 1, release pulse 3 cycles later, no long_press, held never 1.
- Long hold: btn high 20 cycles after press edge E0 -> long_press at E0+8; repeat at E0+12, E0+16, E0+20; held=1 from E0+8 until release; release pulse one cycle after btn falls.
- Boundary tie: btn falls exactly at edge E0+8 -> release pulse, no long_press, held stays 0. Repeat the tie at the E0+12 repeat edge -> release, no repeat.
- REPEAT_EN=0: btn high 30 cycles -> exactly one long_press at E0+8, zero repeat pulses, held=1 until release.
- Reset mid-hold: assert rst while held=1 -> held=0 and state IDLE next cycle, no release pulse. btn still high after rst drops -> new press pulse.
